// File: rtl/csr_timer_pkg.sv
// Shared CSR address map, TCFG field positions and timer control state for csr_timer.
package csr_timer_pkg;

    localparam int CSR_AW = 14;
    localparam int XLEN   = 32;

    // CSR addresses owned by the timer block
    localparam logic [CSR_AW-1:0] CSR_TID   = 14'h040;
    localparam logic [CSR_AW-1:0] CSR_TCFG  = 14'h041;
    localparam logic [CSR_AW-1:0] CSR_TVAL  = 14'h042;
    localparam logic [CSR_AW-1:0] CSR_TICLR = 14'h044;

    // TCFG field positions: En, Periodic, InitVal[31:2]
    localparam int TCFG_EN_BIT       = 0;
    localparam int TCFG_PERIODIC_BIT = 1;
    localparam int TCFG_INITVAL_LSB  = 2;

    // TICLR bit that clears the pending timer interrupt
    localparam int TICLR_CLR_BIT = 0;

    // The run flag is the only control state of the timer
    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    // Per-bit masked CSR update: masked-off bits keep their old value
    function automatic logic [XLEN-1:0] csr_merge(input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [XLEN-1:0] wmask);
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

    // Countdown start value derived from TCFG: {InitVal, 2'b00}
    function automatic logic [XLEN-1:0] tcfg_load_val(input logic [XLEN-1:0] tcfg);
        return tcfg & ~((XLEN'(1) << TCFG_INITVAL_LSB) - XLEN'(1));
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant-frequency timer CSR block: TID/TCFG/TVAL/TICLR registers, countdown
// timer with one-shot/periodic modes, level interrupt and a free-running 64-bit
// stable counter. CSR writes take effect on the next edge; reads are combinational
// from the registered state (no write-to-read bypass).
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter logic [31:0] CORE_ID = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        timer_int,
    output logic [63:0] stable_cnt
);

    tmr_state_e  state_q, state_d;
    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic        ti_q, ti_d;
    logic [63:0] stable_cnt_q;

    logic        wr_tid;
    logic        wr_tcfg;
    logic        wr_ticlr;
    logic        expire;
    logic [31:0] tcfg_new;

    assign wr_tid   = csr_we && (csr_waddr == CSR_TID);
    assign wr_tcfg  = csr_we && (csr_waddr == CSR_TCFG);
    assign wr_ticlr = csr_we && (csr_waddr == CSR_TICLR)
                      && csr_wdata[TICLR_CLR_BIT] && csr_wmask[TICLR_CLR_BIT];
    assign tcfg_new = csr_merge(tcfg_q, csr_wdata, csr_wmask);

    // Expiry happens on the edge where the running counter sits at zero
    assign expire = (state_q == TMR_RUN) && (tval_q == 32'd0);

    // State register; reset overrides any same-cycle write or expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            tid_q   <= CORE_ID;
            tcfg_q  <= 32'd0;
            tval_q  <= 32'd0;
            ti_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            tcfg_q  <= tcfg_d;
            tval_q  <= tval_d;
            ti_q    <= ti_d;
        end
    end

    // Next-state: countdown/reload, interrupt set/clear, then CSR writes override
    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        tcfg_d  = tcfg_q;
        tval_d  = tval_q;
        ti_d    = ti_q;

        if (state_q == TMR_RUN) begin
            if (tval_q != 32'd0) begin
                tval_d = tval_q - 32'd1;
            end else if (tcfg_q[TCFG_PERIODIC_BIT]) begin
                tval_d = tcfg_load_val(tcfg_q);
            end else begin
                // One-shot: stop and park TVAL at zero
                state_d = TMR_IDLE;
            end
        end

        // A clear in the expiry cycle loses to the expiry
        if (wr_ticlr) begin
            ti_d = 1'b0;
        end
        if (expire) begin
            ti_d = 1'b1;
        end

        // A TCFG write always reloads TVAL and sets run from the new En bit
        if (wr_tcfg) begin
            tcfg_d  = tcfg_new;
            tval_d  = tcfg_load_val(tcfg_new);
            state_d = tcfg_new[TCFG_EN_BIT] ? TMR_RUN : TMR_IDLE;
        end

        if (wr_tid) begin
            tid_d = csr_merge(tid_q, csr_wdata, csr_wmask);
        end
    end

    // Free-running stable counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt_q <= 64'd0;
        end else begin
            stable_cnt_q <= stable_cnt_q + 64'd1;
        end
    end

    // Combinational CSR read mux; TICLR and unowned addresses read as zero
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            CSR_TID:  csr_rdata = tid_q;
            CSR_TCFG: csr_rdata = tcfg_q;
            CSR_TVAL: csr_rdata = tval_q;
            default:  csr_rdata = 32'd0;
        endcase
    end

    assign timer_int  = ti_q;
    assign stable_cnt = stable_cnt_q;

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: directed scenarios with fixed expected values
// followed by randomized CSR traffic compared against a cycle-count based model.
module tb_csr_timer;

    localparam logic [31:0] TB_CORE_ID = 32'h0000_00A5;
    localparam logic [13:0] A_TID   = 14'h040;
    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_TICLR = 14'h044;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_we = 1'b0;
    logic [13:0] csr_waddr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_wmask = '0;
    logic [13:0] csr_raddr = '0;
    logic [31:0] csr_rdata;
    logic        timer_int;
    logic [63:0] stable_cnt;

    always #5 clk = ~clk;

    csr_timer #(.CORE_ID(TB_CORE_ID)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_we     (csr_we),
        .csr_waddr  (csr_waddr),
        .csr_wdata  (csr_wdata),
        .csr_wmask  (csr_wmask),
        .csr_raddr  (csr_raddr),
        .csr_rdata  (csr_rdata),
        .timer_int  (timer_int),
        .stable_cnt (stable_cnt)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timer state is described by the config and the number of edges since the
    // last TCFG load; TVAL and expiry instants follow arithmetically from that.
    logic [31:0] m_tid;
    logic [31:0] m_tcfg;
    logic        m_ti;
    logic [63:0] m_cnt;
    longint      m_ph;

    function automatic longint m_start();
        return longint'(m_tcfg) - longint'(m_tcfg % 4);
    endfunction

    function automatic logic [31:0] m_tval();
        longint v;
        v = m_start();
        if (!m_tcfg[0])      return 32'(v);
        if (m_tcfg[1])       return 32'(v - (m_ph % (v + 1)));
        if (m_ph >= v)       return 32'd0;
        return 32'(v - m_ph);
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        if (a == A_TID)  return m_tid;
        if (a == A_TCFG) return m_tcfg;
        if (a == A_TVAL) return m_tval();
        return 32'd0;
    endfunction

    task automatic m_step(input logic rst, input logic we, input logic [13:0] wa,
                          input logic [31:0] wd, input logic [31:0] wm);
        longint v;
        logic   expired;
        if (rst) begin
            m_tid  = TB_CORE_ID;
            m_tcfg = 32'd0;
            m_ti   = 1'b0;
            m_cnt  = 64'd0;
            m_ph   = 0;
            return;
        end
        v = m_start();
        m_ph++;
        if (m_tcfg[1]) expired = m_tcfg[0] && ((m_ph % (v + 1)) == 0);
        else           expired = m_tcfg[0] && (m_ph == v + 1);
        if (we && wa == A_TICLR && wd[0] && wm[0]) m_ti = 1'b0;
        if (expired) m_ti = 1'b1;
        if (we && wa == A_TCFG) begin
            m_tcfg = (m_tcfg & ~wm) | (wd & wm);
            m_ph   = 0;
        end
        if (we && wa == A_TID) m_tid = (m_tid & ~wm) | (wd & wm);
        m_cnt = m_cnt + 64'd1;
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs, take one edge, step the model and compare #1 after the edge.
    task automatic tick(input logic rst, input logic we, input logic [13:0] wa,
                        input logic [31:0] wd, input logic [31:0] wm, input logic [13:0] ra);
        reset     = rst;
        csr_we    = we;
        csr_waddr = wa;
        csr_wdata = wd;
        csr_wmask = wm;
        csr_raddr = ra;
        @(posedge clk);
        m_step(rst, we, wa, wd, wm);
        #1;
        check("model_timer_int", 64'(timer_int), 64'(m_ti));
        check("model_stable_cnt", stable_cnt, m_cnt);
        check("model_rdata", 64'(csr_rdata), 64'(m_read(ra)));
    endtask

    task automatic idle(input logic [13:0] ra);
        tick(1'b0, 1'b0, 14'h0, 32'h0, 32'h0, ra);
    endtask

    task automatic wr(input logic [13:0] wa, input logic [31:0] wd, input logic [13:0] ra);
        tick(1'b0, 1'b1, wa, wd, 32'hFFFF_FFFF, ra);
    endtask

    // Count idle edges until timer_int is seen high; -1 if the budget runs out
    task automatic wait_rise(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            idle(A_TVAL);
            if (timer_int) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    int n;

    initial begin
        m_step(1'b1, 1'b0, 14'h0, 32'h0, 32'h0);

        // Reset state
        tick(1'b1, 1'b0, 14'h0, 32'h0, 32'h0, A_TID);
        tick(1'b1, 1'b0, 14'h0, 32'h0, 32'h0, A_TID);
        check("rst_timer_int", 64'(timer_int), 64'd0);
        check("rst_stable_cnt", stable_cnt, 64'd0);
        check("rst_tid", 64'(csr_rdata), 64'(TB_CORE_ID));
        idle(A_TCFG);
        check("rst_tcfg", 64'(csr_rdata), 64'd0);
        check("cnt_after_rst", stable_cnt, 64'd1);
        idle(A_TICLR);
        check("ticlr_reads_0", 64'(csr_rdata), 64'd0);

        // Periodic: InitVal=4 -> TVAL=0x10, interval 17 edges
        wr(A_TCFG, 32'h13, A_TVAL);
        check("per_load_tval", 64'(csr_rdata), 64'h10);
        wait_rise(n);
        check("per_first_expiry", 64'(n), 64'd17);
        check("per_reload_tval", 64'(csr_rdata), 64'h10);
        wr(A_TICLR, 32'h1, A_TVAL);
        check("ticlr_clears", 64'(timer_int), 64'd0);
        wait_rise(n);
        check("per_second_expiry", 64'(n + 1), 64'd17);

        // TICLR in the expiry cycle: expiry wins
        for (int i = 0; i < 40 && csr_rdata != 32'd0; i++) idle(A_TVAL);
        check("tval_reached_0", 64'(csr_rdata), 64'd0);
        wr(A_TICLR, 32'h1, A_TVAL);
        check("ticlr_vs_expiry", 64'(timer_int), 64'd1);
        wr(A_TICLR, 32'h1, A_TVAL);
        check("ticlr_after", 64'(timer_int), 64'd0);

        // One-shot: InitVal=2 -> TVAL=8, single expiry after 9 edges
        wr(A_TCFG, 32'h09, A_TVAL);
        check("os_load_tval", 64'(csr_rdata), 64'h8);
        wait_rise(n);
        check("os_expiry", 64'(n), 64'd9);
        for (int i = 0; i < 20; i++) idle(A_TVAL);
        check("os_tval_held", 64'(csr_rdata), 64'd0);
        check("os_ti_held", 64'(timer_int), 64'd1);
        wr(A_TICLR, 32'h1, A_TVAL);
        for (int i = 0; i < 30; i++) idle(A_TVAL);
        check("os_no_second", 64'(timer_int), 64'd0);

        // Disable and reload
        wr(A_TCFG, 32'h41, A_TVAL);
        check("dis_load", 64'(csr_rdata), 64'h40);
        for (int i = 0; i < 5; i++) idle(A_TVAL);
        check("dis_counting", 64'(csr_rdata), 64'h3B);
        wr(A_TCFG, 32'h0, A_TVAL);
        for (int i = 0; i < 5; i++) idle(A_TVAL);
        check("dis_frozen_zero", 64'(csr_rdata), 64'd0);
        wr(A_TCFG, 32'h41, A_TVAL);
        for (int i = 0; i < 5; i++) idle(A_TVAL);
        tick(1'b0, 1'b1, A_TCFG, 32'h0, 32'h1, A_TVAL);
        for (int i = 0; i < 5; i++) idle(A_TVAL);
        check("dis_frozen_en_only", 64'(csr_rdata), 64'h40);
        wr(A_TCFG, 32'h41, A_TVAL);
        for (int i = 0; i < 3; i++) idle(A_TVAL);
        wr(A_TCFG, 32'h23, A_TVAL);
        check("reload_midcount", 64'(csr_rdata), 64'h20);

        // Masking: only En changes, Periodic keeps its old value
        wr(A_TCFG, 32'h20, A_TCFG);
        tick(1'b0, 1'b1, A_TCFG, 32'h3, 32'h1, A_TCFG);
        check("mask_en_only", 64'(csr_rdata), 64'h21);

        // TVAL write and unowned write are no-ops
        tick(1'b0, 1'b1, A_TVAL, 32'hFFFF, 32'hFFFF_FFFF, A_TCFG);
        check("tval_write_noop", 64'(csr_rdata), 64'h21);
        tick(1'b0, 1'b1, 14'h123, 32'hFFFF, 32'hFFFF_FFFF, 14'h123);
        check("unowned_read_0", 64'(csr_rdata), 64'd0);

        // Reset mid-count
        wr(A_TCFG, 32'h41, A_TVAL);
        for (int i = 0; i < 3; i++) idle(A_TVAL);
        tick(1'b1, 1'b1, A_TCFG, 32'h13, 32'hFFFF_FFFF, A_TVAL);
        check("midrst_tval", 64'(csr_rdata), 64'd0);
        check("midrst_ti", 64'(timer_int), 64'd0);
        check("midrst_cnt", stable_cnt, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            idle(A_TVAL);
            check("midrst_cnt_inc", stable_cnt, 64'(k));
        end
        check("midrst_stopped", 64'(csr_rdata), 64'd0);

        // Randomized CSR traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_we;
            logic [13:0] r_wa, r_ra;
            logic [31:0] r_wd, r_wm;
            logic [13:0] addrs [5];
            addrs[0] = A_TID;
            addrs[1] = A_TCFG;
            addrs[2] = A_TVAL;
            addrs[3] = A_TICLR;
            addrs[4] = 14'($urandom_range(0, 16383));
            r_rst = ($urandom_range(0, 99) == 0);
            r_we  = ($urandom_range(0, 3) == 0);
            r_wa  = addrs[$urandom_range(0, 4)];
            r_ra  = addrs[$urandom_range(0, 4)];
            if (r_wa == A_TID) r_wd = $urandom;
            else               r_wd = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r_wm  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            tick(r_rst, r_we, r_wa, r_wd, r_wm, r_ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
